// File: rtl/io_key_sw_if.sv
// CPU-side load/store bus into the KEY/SW I/O block.
// Master drives address and access strobes; slave returns data, decode hit and interrupt.
interface io_key_sw_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic             mem_re;
  logic             mem_we;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic             hit;
  logic             irq;

  // No valid/ready handshake: an access is a single cycle qualified by mem_re/mem_we,
  // and rdata/hit are combinational from addr within that same cycle.
  modport master (
    output addr, mem_re, mem_we, wdata,
    input  rdata, hit, irq
  );

  modport slave (
    input  addr, mem_re, mem_we, wdata,
    output rdata, hit, irq
  );
endinterface

// File: rtl/io_key_sw_ctrl.sv
// Memory-mapped KEY/SW input block: synchronize, debounce, latch change events
// into Ready/Overrun status, and return register data on the load path.
module io_key_sw_ctrl #(
  parameter int                 DBITS           = 32,
  parameter int                 DEBOUNCE_CYCLES = 100000,
  parameter logic [DBITS-1:0]   ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0]   ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0]   ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0]   ADDR_SCTRL      = 32'hF0000114
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_raw,
  input  logic [9:0]       sw_raw,
  io_key_sw_if.slave       bus
);
  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    key_s1, key_s2;
  logic [9:0]    sw_s1, sw_s2;
  logic [13:0]   sync_v, deb, deb_upd;
  logic [CW-1:0] cnt [14];

  // KEY synchronizers idle at 1 because the pins are active-low.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= 4'hF;
      key_s2 <= 4'hF;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
    end
  end

  // Bits [3:0] are keys (1 = pressed), bits [13:4] are switches.
  assign sync_v = {sw_s2, ~key_s2};

  always_comb begin
    deb_upd = '0;
    for (int i = 0; i < 14; i++)
      deb_upd[i] = (sync_v[i] != deb[i]) && (cnt[i] == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < 14; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (sync_v[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync_v[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Status channels: index 0 = KEY, index 1 = SW.
  logic [1:0] evt, data_rd, ctrl_wr, clr_acc;
  logic [1:0] rdy, ovr, ie, rdy_n, ovr_n, ie_n;
  logic       rd_ok;

  assign evt        = {|deb_upd[13:4], |deb_upd[3:0]};
  assign rd_ok      = bus.mem_re & ~bus.mem_we;
  assign data_rd[0] = rd_ok & (bus.addr == ADDR_KEY);
  assign data_rd[1] = rd_ok & (bus.addr == ADDR_SW);
  assign ctrl_wr[0] = bus.mem_we & (bus.addr == ADDR_KCTRL);
  assign ctrl_wr[1] = bus.mem_we & (bus.addr == ADDR_SCTRL);
  assign clr_acc    = data_rd | (ctrl_wr & {2{~bus.wdata[0]}});

  // A new event always wins over a clearing access in the same cycle.
  always_comb begin
    rdy_n = rdy;
    ovr_n = ovr;
    ie_n  = ie;
    for (int c = 0; c < 2; c++) begin
      if (evt[c])          rdy_n[c] = 1'b1;
      else if (clr_acc[c]) rdy_n[c] = 1'b0;
      if (ctrl_wr[c] && !bus.wdata[2])          ovr_n[c] = 1'b0;
      if (evt[c] && rdy[c] && !clr_acc[c])      ovr_n[c] = 1'b1;
      if (ctrl_wr[c])                           ie_n[c]  = bus.wdata[8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy <= '0;
      ovr <= '0;
      ie  <= '0;
    end else begin
      rdy <= rdy_n;
      ovr <= ovr_n;
      ie  <= ie_n;
    end
  end

  always_comb begin
    bus.rdata = '0;
    bus.hit   = 1'b1;
    case (bus.addr)
      ADDR_KEY:   bus.rdata = DBITS'(deb[3:0]);
      ADDR_SW:    bus.rdata = DBITS'(deb[13:4]);
      ADDR_KCTRL: bus.rdata = DBITS'({ie[0], 5'b0, ovr[0], 1'b0, rdy[0]});
      ADDR_SCTRL: bus.rdata = DBITS'({ie[1], 5'b0, ovr[1], 1'b0, rdy[1]});
      default:    bus.hit   = 1'b0;
    endcase
  end

  assign bus.irq = |(rdy & ie);
endmodule

// File: doc/io_key_sw_ctrl.md
Name: io_key_sw_ctrl

Overview:
Memory-mapped input controller for the board KEY and SW pins. It sits directly upstream of the data-memory read path. It synchronizes and debounces the raw pins, latches change events into status bits, and returns register data to the CPU's load mux when an address hits its I/O window. This gives software polled (and optionally interrupt-flagged) edge detection in place of raw level reads.

Parameters:
DBITS, 32, data and address width
DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before a debounced bit updates; must be >= 2
ADDR_KEY, 32'hF0000010, KDATA register address
ADDR_SW, 32'hF0000014, SDATA register address
ADDR_KCTRL, 32'hF0000110, KEY control/status register address
ADDR_SCTRL, 32'hF0000114, SW control/status register address

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
key_raw  in  4  board KEY pins, active-low (0 = pressed)
sw_raw  in  10  board SW pins, active-high
addr  in  DBITS  byte address from the ALU result
mem_re  in  1  load in progress this cycle
mem_we  in  1  store in progress this cycle
wdata  in  DBITS  store data
rdata  out  DBITS  read data, combinational; zero when there is no hit
hit  out  1  addr equals one of the four register addresses
irq  out  1  (KCTRL.Ready & KCTRL.IE) | (SCTRL.Ready & SCTRL.IE)

Behaviour:
- Sync: each raw bit passes through a 2-flop synchronizer. KEY is inverted after sync, so 1 = pressed.
- Debounce: each of the 14 bits has its own counter.
  - sync != deb: counter increments.
  - sync != deb and counter == DEBOUNCE_CYCLES-1: deb <= sync and counter <= 0.
  - sync == deb: counter <= 0.
  - Net latency: a raw change held stable appears in deb DEBOUNCE_CYCLES+2 edges after the raw change. Any bounce restarts the count.
- Change event: key_evt is high when any key deb bit updates this cycle. sw_evt is the same for switches.
- KDATA read value: {28'b0, key_deb}. SDATA read value: {22'b0, sw_deb}. Writes to either data register are ignored.
- KCTRL/SCTRL read value: bit0 Ready, bit2 Overrun, bit8 IE, all other bits 0.
- Ready and Overrun update at each edge:
  - Event and Ready=0: Ready <= 1.
  - Event and Ready=1 and no clearing access this cycle: Overrun <= 1.
  - Read of the data register (mem_re & addr hit) with no event: Ready <= 0.
  - Read and event in the same cycle: Ready stays 1, Overrun unchanged (the new event wins).
- CTRL writes (mem_we & addr hit):
  - wdata[0]==0 clears Ready; wdata[2]==0 clears Overrun. Writing 1 to bit0 or bit2 never sets it.
  - IE <= wdata[8].
  - If an event coincides with a write that clears Ready, Ready stays 1.
- mem_re and mem_we are never both 1. If they are, the write is honoured and the read side effect is suppressed.
- rdata is purely combinational from addr and the current registers, so it is valid in the same cycle.
- Reset values:
  - Synchronizers 0 (KEY sync 1 pre-inversion), deb 0, counters 0.
  - Ready 0, Overrun 0, IE 0.
  - rdata and hit follow addr; irq 0.
- Reset asserted mid-debounce discards counter progress. Switches held at 1 through reset generate an sw_evt DEBOUNCE_CYCLES+2 cycles after reset deasserts; this is expected.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps because it saturates by resetting at DEBOUNCE_CYCLES-1.

Test Plan:
- DEBOUNCE_CYCLES=4, reset, key_raw=4'hF: after 10 cycles KDATA reads 0, KCTRL reads 0, irq=0, hit=1 only at the four addresses.
- key_raw drops to 4'hE and holds: KDATA reads 1 exactly 6 edges later, KCTRL reads 32'h1 the same cycle, and a KDATA read clears KCTRL bit0 on the next edge.
- key_raw toggles 4'hE/4'hF every 2 cycles for 20 cycles: KDATA stays 0 and Ready stays 0.
- sw_raw=10'h001 is debounced (Ready=1) and left unread, then sw_raw=10'h003: SCTRL reads 32'h5. Writing 32'h0 to SCTRL then reads 32'h0.
- Write 32'h100 to KCTRL, then press KEY[3]: irq rises in the same cycle KDATA becomes 32'h8. A KDATA read drops irq next edge; KCTRL reads 32'h100.
- A KDATA read is issued in the exact cycle a new key event lands: Ready remains 1 and Overrun remains 0.
